axis_m: RTL
===========

AXIS_M -- requirements
Module: axis_m

Interface
REQ-001 Parameter WIDTH, default 32, is the data width in bits of both the internal and the AXI-Stream side.
REQ-002 Parameter DEPTH, default 4, is the buffer depth in beats; it SHALL be a power of two and at least 2.
REQ-003 clk  input  1  is the single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  is the reset; it SHALL be asynchronous and active-low.
REQ-005 valid_in  input  1  means the internal producer offers a beat.
REQ-006 data_in  input  WIDTH  is the internal beat payload.
REQ-007 last_in  input  1  marks the final beat of a packet.
REQ-008 ready_in  output  1  means axis_m accepts a beat this cycle.
REQ-009 m_axis_tdata  output  WIDTH  is the AXI-Stream data.
REQ-010 m_axis_tvalid  output  1  is the AXI-Stream valid.
REQ-011 m_axis_tlast  output  1  is the AXI-Stream last.
REQ-012 m_axis_tready  input  1  is the AXI-Stream ready from the downstream slave.
REQ-013 level  output  $clog2(DEPTH)+1  is the number of beats currently buffered.
REQ-014 pkt_cnt  output  16  is the count of completed packets (see Configuration).

Function
REQ-015 The module SHALL write {last_in, data_in} into the buffer tail when valid_in and ready_in are both high.
REQ-016 ready_in SHALL equal (level != DEPTH); there is no bypass, so a full buffer refuses a write even while a pop occurs in the same cycle.
REQ-017 The buffer SHALL be first-word-fall-through: m_axis_tvalid = (level != 0), and tdata/tlast show the head entry combinationally.
REQ-018 A pop SHALL occur when m_axis_tvalid and m_axis_tready are both high; the head then advances on that edge.
REQ-019 Latency SHALL be one cycle: a beat written into an empty buffer at edge N appears on m_axis_tvalid after edge N.
REQ-020 Once m_axis_tvalid is high, it and the tdata/tlast values SHALL stay stable until the handshake, per the AXI-Stream rule.
REQ-021 A simultaneous push and pop SHALL leave level unchanged; a push alone adds 1; a pop alone subtracts 1.
REQ-022 The read and write pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or go below 0.
REQ-023 Beat order and tlast placement SHALL be preserved exactly; the module never merges, splits or drops beats.
REQ-024 valid_in asserted while ready_in is low SHALL have no effect; the producer holds the beat.

Reset
REQ-025 While rst_n is low: pointers = 0, level = 0, m_axis_tvalid = 0, ready_in = 1, pkt_cnt = 0.
REQ-026 Reset asserted mid-packet SHALL discard all buffered beats immediately, without waiting for a clock edge.
REQ-027 tdata/tlast are don't-care while m_axis_tvalid is 0; buffer storage needs no reset.

Configuration
REQ-028 Macro AXIS_M_PKT_CNT_EN, when defined, SHALL enable pkt_cnt, which increments by 1 on each pop with m_axis_tlast = 1 and wraps 0xFFFF -> 0x0000.
REQ-029 When AXIS_M_PKT_CNT_EN is undefined, the pkt_cnt port SHALL remain present, be tied to 0, and have no counter register.

Structure
REQ-030 A shared package axis_pkg SHALL hold the default WIDTH and DEPTH, the 16-bit pkt_cnt type, and a beat struct {last, data}.
REQ-031 Storage and pointer logic SHALL live in a single sub-module, axis_m_buf (circular buffer plus level); axis_m contains only the handshake glue and the optional counter.

Verification
REQ-032 Reset, then push 0xA0 with last=0 at edge 1 -> tvalid=1 and tdata=0xA0 after edge 1; with tready=1, tvalid=0 after edge 2.
REQ-033 tready=0, push 4 beats 0x1..0x4 -> level=4, ready_in=0; a 5th valid_in is ignored; tready=1 for 4 cycles -> output 0x1,0x2,0x3,0x4 in order.
REQ-034 Full buffer, valid_in=1 and tready=1 in the same cycle -> one pop, no push, level 4->3; the next cycle accepts the push.
REQ-035 Continuous valid_in and tready with level=1 for 100 cycles -> level stays 1, throughput is 1 beat/cycle, and tlast appears on the correct beats.
REQ-036 With AXIS_M_PKT_CNT_EN: preload pkt_cnt=0xFFFE via 2 packets short of wrap, send 3 single-beat packets -> pkt_cnt reads 0xFFFF, then 0x0000, then 0x0001; without the macro, pkt_cnt reads 0 throughout.
REQ-037 Assert rst_n low asynchronously with level=3 mid-packet -> tvalid and level drop to 0 before the next edge; after release, a new packet passes cleanly.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared defaults and types for the axis_m stream master.
package axis_pkg;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefDepth = 4;

  typedef logic [15:0] pkt_cnt_t;

  typedef struct packed {
    logic                last;
    logic [DefWidth-1:0] data;
  } beat_t;

endpackage

// File: rtl/axis_m_if.sv
// Producer-side and AXI-Stream handshake bundle for axis_m.
interface axis_m_if #(
  parameter int unsigned WIDTH = axis_pkg::DefWidth
);

  logic             valid_in;
  logic [WIDTH-1:0] data_in;
  logic             last_in;
  logic             ready_in;
  logic [WIDTH-1:0] m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tlast;
  logic             m_axis_tready;

  // axis_m side: accepts producer beats, drives the stream.
  modport master (
    input  valid_in, data_in, last_in, m_axis_tready,
    output ready_in, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  // Producer / downstream side.
  modport slave (
    output valid_in, data_in, last_in, m_axis_tready,
    input  ready_in, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

endinterface

// File: rtl/axis_m_buf.sv
// Circular first-word-fall-through beat buffer with occupancy level.
module axis_m_buf
  import axis_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned LvlW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             wlast_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             rlast_o,
  output logic [LvlW-1:0]  level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic [WIDTH:0]  mem_q [DEPTH];

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push_i, pop_i})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is only observed behind a non-zero level, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= {wlast_i, wdata_i};
  end

  assign {rlast_o, rdata_o} = mem_q[rd_ptr_q];
  assign level_o            = level_q;
  assign full_o             = (level_q == LvlW'(DEPTH));
  assign empty_o            = (level_q == '0);

endmodule

// File: rtl/axis_m.sv
// AXI-Stream master: buffers producer beats and presents them on m_axis_*.
// Define AXIS_M_PKT_CNT_EN to enable the completed-packet counter on pkt_cnt.
module axis_m
  import axis_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic                       clk,
  input  logic                       rst_n,
  axis_m_if.master                   bus,
  output logic [$clog2(DEPTH):0]     level,
  output pkt_cnt_t                   pkt_cnt
);

  logic push, pop, full, empty;

  // No bypass: a full buffer refuses even when a pop happens the same cycle.
  assign bus.ready_in      = !full;
  assign bus.m_axis_tvalid = !empty;
  assign push              = bus.valid_in && !full;
  assign pop               = !empty && bus.m_axis_tready;

  axis_m_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .wdata_i (bus.data_in),
    .wlast_i (bus.last_in),
    .pop_i   (pop),
    .rdata_o (bus.m_axis_tdata),
    .rlast_o (bus.m_axis_tlast),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

`ifdef AXIS_M_PKT_CNT_EN
  pkt_cnt_t pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (pop && bus.m_axis_tlast) pkt_cnt_d = pkt_cnt_q + pkt_cnt_t'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pkt_cnt_q <= '0;
    else        pkt_cnt_q <= pkt_cnt_d;
  end

  assign pkt_cnt = pkt_cnt_q;
`else
  assign pkt_cnt = '0;
`endif

endmodule
